// File: rtl/rsa_wrapper_pkg.sv
// Shared widths, command codes and top-level state encoding for the RSA accelerator.
// Pure declarations: no logic, no latency, no flow control.
package rsa_wrapper_pkg;
    localparam int OPW      = 512;
    localparam int BUSW     = 1024;
    localparam int MONT_BPC = 16;   // multiplier bits retired per clock

    localparam logic [31:0] CMD_COMPUTE_EXP  = 32'd0;
    localparam logic [31:0] CMD_COMPUTE_MONT = 32'd1;
    localparam logic [31:0] CMD_READ_MOD     = 32'd2;
    localparam logic [31:0] CMD_READ_RSQ     = 32'd3;
    localparam logic [31:0] CMD_READ_EXP     = 32'd4;
    localparam logic [31:0] CMD_WRITE        = 32'd5;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RX         = 4'd1,
        ST_TX         = 4'd2,
        ST_MONT_START = 4'd3,
        ST_MONT_WAIT  = 4'd4,
        ST_EXP_PRE    = 4'd5,
        ST_EXP_SQ     = 4'd6,
        ST_EXP_MUL    = 4'd7,
        ST_EXP_POST   = 4'd8,
        ST_DONE       = 4'd9
    } state_t;
endpackage

// File: rtl/rsa_wrapper_montgomery.sv
// Radix-2 Montgomery product a*b*2^-512 mod m, MONT_BPC bits per cycle.
// Latency OPW/MONT_BPC+2 cycles from start to the one-cycle done pulse; start restarts.
// No backpressure: result holds until the next start completes.
module montgomery
    import rsa_wrapper_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [OPW-1:0] in_a,
    input  logic [OPW-1:0] in_b,
    input  logic [OPW-1:0] in_m,
    output logic [OPW-1:0] result,
    output logic           done
);
    localparam int ITERS = OPW / MONT_BPC;
    localparam int CW    = $clog2(ITERS);

    logic          busy, fin;
    logic [CW-1:0] cnt;
    logic [OPW-1:0] a_sh, b_q, m_q;
    logic [OPW+1:0] t_q, t_nxt, t_red;

    // Partial sum stays below 2m, so two guard bits cover the pre-shift value.
    always_comb begin
        t_nxt = t_q;
        for (int k = 0; k < MONT_BPC; k++) begin
            if (a_sh[k]) t_nxt = t_nxt + {2'b00, b_q};
            if (t_nxt[0]) t_nxt = t_nxt + {2'b00, m_q};
            t_nxt = t_nxt >> 1;
        end
    end

    assign t_red = (t_q >= {2'b00, m_q}) ? t_q - {2'b00, m_q} : t_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy   <= 1'b0;
            fin    <= 1'b0;
            cnt    <= '0;
            a_sh   <= '0;
            b_q    <= '0;
            m_q    <= '0;
            t_q    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                fin  <= 1'b0;
                cnt  <= '0;
                a_sh <= in_a;
                b_q  <= in_b;
                m_q  <= in_m;
                t_q  <= '0;
            end else if (busy) begin
                t_q  <= t_nxt;
                a_sh <= a_sh >> MONT_BPC;
                cnt  <= cnt + 1'b1;
                if (cnt == CW'(ITERS - 1)) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end
            end else if (fin) begin
                fin    <= 1'b0;
                result <= t_red[OPW-1:0];
                done   <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/rsa_wrapper.sv
// RSA shell: command decode, operand load/store, Montgomery product and modexp sequencing.
// Latency: load/store a few cycles, exp ~(514+popcount(E)) multiplier calls.
// Backpressure: RX waits for data_valid, TX waits for data_ready, DONE waits for done_read.
module rsa_wrapper
    import rsa_wrapper_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     arm_to_fpga_cmd,
    input  logic            arm_to_fpga_cmd_valid,
    output logic            fpga_to_arm_done,
    input  logic            fpga_to_arm_done_read,
    input  logic            arm_to_fpga_data_valid,
    output logic            arm_to_fpga_data_ready,
    input  logic [BUSW-1:0] arm_to_fpga_data,
    output logic            fpga_to_arm_data_valid,
    input  logic            fpga_to_arm_data_ready,
    output logic [BUSW-1:0] fpga_to_arm_data,
    output logic [3:0]      leds
);
    state_t         state_q, state_d;
    logic [31:0]    cmd_q;
    logic [OPW-1:0] m_q, x_q, s_q, rm_q, e_q, res_q, xm_q, acc_q;
    logic [8:0]     bit_q;
    logic           call_q, rdy_hold_q, tx_hold_q;
    logic           mont_start, mont_done, rx_take, exp_state, ack;
    logic [OPW-1:0] op_a, op_b, mont_res;

    montgomery u_mont (
        .clk    (clk),
        .resetn (resetn),
        .start  (mont_start),
        .in_a   (op_a),
        .in_b   (op_b),
        .in_m   (m_q),
        .result (mont_res),
        .done   (mont_done)
    );

    assign rx_take   = (state_q == ST_RX) && arm_to_fpga_data_valid;
    assign ack       = (state_q == ST_DONE) && fpga_to_arm_done_read;
    assign exp_state = (state_q == ST_EXP_PRE) || (state_q == ST_EXP_SQ) ||
                       (state_q == ST_EXP_MUL) || (state_q == ST_EXP_POST);

    always_comb begin
        state_d    = state_q;
        op_a       = s_q;
        op_b       = x_q;
        mont_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    case (arm_to_fpga_cmd)
                        CMD_COMPUTE_EXP:  state_d = ST_EXP_PRE;
                        CMD_COMPUTE_MONT: state_d = ST_MONT_START;
                        CMD_READ_MOD,
                        CMD_READ_RSQ,
                        CMD_READ_EXP:     state_d = ST_RX;
                        CMD_WRITE:        state_d = ST_TX;
                        default:          state_d = ST_DONE;
                    endcase
                end
            end
            ST_RX:         if (rx_take) state_d = ST_DONE;
            ST_TX:         if (fpga_to_arm_data_ready) state_d = ST_DONE;
            ST_MONT_START: begin
                mont_start = 1'b1;
                state_d    = ST_MONT_WAIT;
            end
            ST_MONT_WAIT:  if (mont_done) state_d = ST_DONE;
            ST_EXP_PRE: begin
                op_a = x_q;
                op_b = s_q;
                if (mont_done) state_d = ST_EXP_SQ;
            end
            ST_EXP_SQ: begin
                op_a = acc_q;
                op_b = acc_q;
                if (mont_done) begin
                    if (e_q[bit_q])       state_d = ST_EXP_MUL;
                    else if (bit_q == '0) state_d = ST_EXP_POST;
                end
            end
            ST_EXP_MUL: begin
                op_a = acc_q;
                op_b = xm_q;
                if (mont_done) state_d = (bit_q == '0) ? ST_EXP_POST : ST_EXP_SQ;
            end
            ST_EXP_POST: begin
                op_a = acc_q;
                op_b = OPW'(1);
                if (mont_done) state_d = ST_DONE;
            end
            ST_DONE:       if (fpga_to_arm_done_read) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        // Every exp step fires the multiplier once on entry; call_q blocks re-issue.
        if (exp_state && !call_q) mont_start = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            m_q        <= '0;
            x_q        <= '0;
            s_q        <= '0;
            rm_q       <= '0;
            e_q        <= '0;
            res_q      <= '0;
            xm_q       <= '0;
            acc_q      <= '0;
            bit_q      <= '0;
            call_q     <= 1'b0;
            rdy_hold_q <= 1'b0;
            tx_hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arm_to_fpga_cmd_valid) cmd_q <= arm_to_fpga_cmd;
            if (rx_take) begin
                case (cmd_q)
                    CMD_READ_MOD: m_q <= arm_to_fpga_data[OPW-1:0];
                    CMD_READ_RSQ: begin
                        x_q <= arm_to_fpga_data[BUSW-1:OPW];
                        s_q <= arm_to_fpga_data[OPW-1:0];
                    end
                    CMD_READ_EXP: begin
                        rm_q <= arm_to_fpga_data[BUSW-1:OPW];
                        e_q  <= arm_to_fpga_data[OPW-1:0];
                    end
                    default: ;
                endcase
            end
            if (rx_take)   rdy_hold_q <= 1'b1;
            else if (ack)  rdy_hold_q <= 1'b0;
            if (state_q == ST_TX) tx_hold_q <= 1'b1;
            else if (ack)         tx_hold_q <= 1'b0;
            if (exp_state) begin
                if (mont_done)       call_q <= 1'b0;
                else if (mont_start) call_q <= 1'b1;
            end
            if (mont_done) begin
                case (state_q)
                    ST_MONT_WAIT: res_q <= mont_res;
                    ST_EXP_PRE: begin
                        xm_q  <= mont_res;
                        acc_q <= rm_q;
                        bit_q <= 9'd511;
                    end
                    ST_EXP_SQ: begin
                        acc_q <= mont_res;
                        if (!e_q[bit_q] && bit_q != '0) bit_q <= bit_q - 1'b1;
                    end
                    ST_EXP_MUL: begin
                        acc_q <= mont_res;
                        if (bit_q != '0) bit_q <= bit_q - 1'b1;
                    end
                    ST_EXP_POST: res_q <= mont_res;
                    default: ;
                endcase
            end
        end
    end

    assign fpga_to_arm_done       = (state_q == ST_DONE);
    assign arm_to_fpga_data_ready = rdy_hold_q || rx_take;
    assign fpga_to_arm_data_valid = (state_q == ST_TX) || tx_hold_q;
    assign fpga_to_arm_data       = {{(BUSW-OPW){1'b0}}, res_q};
    assign leds                   = state_q;
endmodule

// File: tb/tb_rsa_wrapper.sv
// Directed self-checking bench for rsa_wrapper with hand-computed M=7 vectors.
module tb_rsa_wrapper;
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   arm_to_fpga_cmd = '0;
    logic          arm_to_fpga_cmd_valid = 1'b0;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read = 1'b0;
    logic          arm_to_fpga_data_valid = 1'b0;
    logic          arm_to_fpga_data_ready;
    logic [1023:0] arm_to_fpga_data = '0;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready = 1'b0;
    logic [1023:0] fpga_to_arm_data;
    logic [3:0]    leds;

    int total = 0;
    int bad   = 0;

    rsa_wrapper dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .leds                   (leds)
    );

    always #5 clk = ~clk;

    // Issue one command and wait (bounded) for done; optionally acknowledge it.
    task automatic run_cmd(input logic [31:0] code, input logic [1023:0] din, input int bound,
                           input bit do_ack, output bit ok, output int cycles,
                           output logic [1023:0] rd);
        arm_to_fpga_data       = din;
        arm_to_fpga_data_valid = (code >= 32'd2 && code <= 32'd4);
        fpga_to_arm_data_ready = 1'b1;
        arm_to_fpga_cmd        = code;
        arm_to_fpga_cmd_valid  = 1'b1;
        @(posedge clk); #1;
        arm_to_fpga_cmd_valid  = 1'b0;
        cycles = 1;
        while (!fpga_to_arm_done && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
        end
        ok = fpga_to_arm_done;
        rd = fpga_to_arm_data;
        if (do_ack) ack_done();
    endtask

    task automatic ack_done();
        fpga_to_arm_done_read = 1'b1;
        @(posedge clk); #1;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [1023:0] rd;
        bit ok;
        int cyc;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (fpga_to_arm_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", fpga_to_arm_done); end
        total++; if (arm_to_fpga_data_ready !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b want=0", arm_to_fpga_data_ready); end
        total++; if (fpga_to_arm_data_valid !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", fpga_to_arm_data_valid); end
        total++; if (leds !== 4'd0) begin bad++; $display("FAIL rst_leds got=%0d want=0", leds); end
        total++; if (fpga_to_arm_data !== '0) begin bad++; $display("FAIL rst_data got=%0h want=0", fpga_to_arm_data[511:0]); end
        resetn = 1'b1;
        @(posedge clk); #1;
        run_cmd(32'd5, '0, 10, 1'b1, ok, cyc, rd);
        total++; if (ok !== 1'b1 || rd !== '0) begin bad++; $display("FAIL rst_write got=%0h ok=%b want=0 ok=1", rd[511:0], ok); end
    endtask

    task automatic test_mont();
        logic [1023:0] rd;
        bit ok, all_ok;
        int cyc;
        all_ok = 1'b1;
        run_cmd(32'd2, {512'd0, 512'd7}, 10, 1'b1, ok, cyc, rd);   all_ok &= ok;
        run_cmd(32'd3, {512'd3, 512'd2}, 10, 1'b1, ok, cyc, rd);   all_ok &= ok;
        run_cmd(32'd1, '0, 200, 1'b1, ok, cyc, rd);                all_ok &= ok;
        run_cmd(32'd5, '0, 10, 1'b1, ok, cyc, rd);                 all_ok &= ok;
        total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL mont_timeout got=%b want=1", all_ok); end
        total++; if (rd[511:0] !== 512'd5) begin bad++; $display("FAIL mont_low got=%0d want=5", rd[511:0]); end
        total++; if (rd[1023:512] !== 512'd0) begin bad++; $display("FAIL mont_high got=%0h want=0", rd[1023:512]); end
    endtask

    task automatic test_exp();
        logic [511:0] e_tab [3];
        logic [511:0] r_tab [3];
        logic [1023:0] rd;
        bit ok, all_ok;
        int cyc, exp_cyc;
        e_tab = '{512'd5, 512'd0, 512'd1};
        r_tab = '{512'd5, 512'd1, 512'd3};
        for (int v = 0; v < 3; v++) begin
            all_ok = 1'b1;
            run_cmd(32'd3, {512'd3, 512'd2}, 10, 1'b1, ok, cyc, rd);      all_ok &= ok;
            run_cmd(32'd4, {512'd4, e_tab[v]}, 10, 1'b1, ok, cyc, rd);    all_ok &= ok;
            run_cmd(32'd0, '0, 25000, 1'b1, ok, exp_cyc, rd);             all_ok &= ok;
            run_cmd(32'd5, '0, 10, 1'b1, ok, cyc, rd);                    all_ok &= ok;
            total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL exp_timeout[%0d] got=%b want=1", v, all_ok); end
            total++; if (rd[511:0] !== r_tab[v]) begin bad++; $display("FAIL exp_result[%0d] got=%0d want=%0d", v, rd[511:0], r_tab[v]); end
            // Processing all 512 exponent bits takes far more than 1024 cycles.
            total++; if (exp_cyc <= 1024) begin bad++; $display("FAIL exp_noskip[%0d] got=%0d cycles want>1024", v, exp_cyc); end
        end
    endtask

    task automatic test_unknown();
        logic [1023:0] rd;
        bit ok;
        int cyc;
        run_cmd(32'd9, '0, 3, 1'b1, ok, cyc, rd);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL unk_done got=%b cycles=%0d want=1 within 3", ok, cyc); end
        run_cmd(32'd5, '0, 10, 1'b1, ok, cyc, rd);
        total++; if (rd[511:0] !== 512'd3) begin bad++; $display("FAIL unk_regs got=%0d want=3", rd[511:0]); end
    endtask

    task automatic test_handshake();
        logic [1023:0] rd;
        bit ok;
        int cyc;
        run_cmd(32'd2, {512'd0, 512'd7}, 10, 1'b0, ok, cyc, rd);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL hs_rx_done got=%b want=1", ok); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin arm_to_fpga_cmd = 32'd1; arm_to_fpga_cmd_valid = 1'b1; end
            if (i == 6) arm_to_fpga_cmd_valid = 1'b0;
            total++; if (fpga_to_arm_done !== 1'b1 || arm_to_fpga_data_ready !== 1'b1) begin
                bad++; $display("FAIL hs_rx_hold[%0d] got done=%b rdy=%b want 1/1", i, fpga_to_arm_done, arm_to_fpga_data_ready);
            end
            @(posedge clk); #1;
        end
        total++; if (leds !== 4'd9) begin bad++; $display("FAIL hs_leds_done got=%0d want=9", leds); end
        ack_done();
        total++; if (leds !== 4'd0 || arm_to_fpga_data_ready !== 1'b0) begin
            bad++; $display("FAIL hs_rx_ack got leds=%0d rdy=%b want 0/0", leds, arm_to_fpga_data_ready);
        end
        run_cmd(32'd5, '0, 10, 1'b0, ok, cyc, rd);
        for (int i = 0; i < 20; i++) begin
            total++; if (fpga_to_arm_done !== 1'b1 || fpga_to_arm_data_valid !== 1'b1) begin
                bad++; $display("FAIL hs_tx_hold[%0d] got done=%b vld=%b want 1/1", i, fpga_to_arm_done, fpga_to_arm_data_valid);
            end
            @(posedge clk); #1;
        end
        ack_done();
        total++; if (fpga_to_arm_data_valid !== 1'b0 || fpga_to_arm_done !== 1'b0) begin
            bad++; $display("FAIL hs_tx_ack got vld=%b done=%b want 0/0", fpga_to_arm_data_valid, fpga_to_arm_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] rd;
        bit ok, all_ok;
        int cyc;
        arm_to_fpga_cmd       = 32'd0;
        arm_to_fpga_cmd_valid = 1'b1;
        @(posedge clk); #1;
        arm_to_fpga_cmd_valid = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        total++; if (!(leds == 4'd6 || leds == 4'd7)) begin bad++; $display("FAIL mid_busy got leds=%0d want 6 or 7", leds); end
        resetn = 1'b0;
        #1;
        total++; if (leds !== 4'd0 || fpga_to_arm_done !== 1'b0 || fpga_to_arm_data !== '0 ||
                     fpga_to_arm_data_valid !== 1'b0 || arm_to_fpga_data_ready !== 1'b0) begin
            bad++; $display("FAIL mid_reset got leds=%0d done=%b vld=%b rdy=%b want all 0",
                            leds, fpga_to_arm_done, fpga_to_arm_data_valid, arm_to_fpga_data_ready);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        all_ok = 1'b1;
        run_cmd(32'd2, {512'd0, 512'd7}, 10, 1'b1, ok, cyc, rd);   all_ok &= ok;
        run_cmd(32'd3, {512'd3, 512'd2}, 10, 1'b1, ok, cyc, rd);   all_ok &= ok;
        run_cmd(32'd1, '0, 200, 1'b1, ok, cyc, rd);                all_ok &= ok;
        run_cmd(32'd5, '0, 10, 1'b1, ok, cyc, rd);                 all_ok &= ok;
        total++; if (all_ok !== 1'b1 || rd[511:0] !== 512'd5) begin
            bad++; $display("FAIL mid_recover got=%0d ok=%b want=5 ok=1", rd[511:0], all_ok);
        end
    endtask

    initial begin
        test_reset();
        test_mont();
        test_exp();
        test_unknown();
        test_handshake();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rsa_wrapper.md
# rsa_wrapper

Top-level RSA accelerator shell between the ARM-side command/data interface and a 512-bit Montgomery multiplier. It decodes 32-bit commands, loads 1024-bit words into operand registers, and runs a single Montgomery product or a full modular exponentiation x^e mod M. It returns 1024-bit results and signals completion via a done/done-read handshake. Modulus width is 512 bits and R = 2^512.

## Interface
- No parameters; operand width fixed at 512, bus width at 1024.
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- arm_to_fpga_cmd  in  32  command code, sampled when cmd_valid=1 in IDLE
- arm_to_fpga_cmd_valid  in  1  one-cycle command strobe
- fpga_to_arm_done  out  1  command finished; held until done_read
- fpga_to_arm_done_read  in  1  one-cycle acknowledge of done
- arm_to_fpga_data_valid  in  1  input word valid
- arm_to_fpga_data_ready  out  1  input word captured; held until done acknowledged
- arm_to_fpga_data  in  1024  input word
- fpga_to_arm_data_valid  out  1  output word valid
- fpga_to_arm_data_ready  in  1  host ready to take output word
- fpga_to_arm_data  out  1024  {512'b0, result}
- leds  out  4  current top-level state code

## Operation
- Commands: 0 COMPUTE_EXP, 1 COMPUTE_MONT, 2 READ_MOD, 3 READ_RSQ, 4 READ_EXP, 5 WRITE. Codes ≥6 go straight to DONE with no side effect.
- READ_MOD: M ← data[511:0]; data[1023:512] is ignored.
- READ_RSQ: X ← data[1023:512] (base, or B); S ← data[511:0] (R² mod M, or A).
- READ_EXP: RM ← data[1023:512] (R mod M); E ← data[511:0] (exponent).
- COMPUTE_MONT: result ← S·X·R⁻¹ mod M, one multiplier call.
- COMPUTE_EXP:
  - PRE: Xm ← Mont(X,S); A ← RM.
  - For i = 511 down to 0: SQ A ← Mont(A,A); if E[i], MUL A ← Mont(A,Xm).
  - POST: result ← Mont(A,1).
  - All 512 bits are processed; leading zeros are not skipped.
- WRITE: present result; complete on transfer.
- Preconditions: M odd, X and S < M. Behaviour outside these is undefined but must not hang.
- States: IDLE, RX, TX, MONT_START, MONT_WAIT, EXP_PRE, EXP_SQ, EXP_MUL, EXP_POST, DONE. leds encode the state index.

## Timing
- Reset: all outputs 0; M, X, S, RM, E, result cleared; state IDLE. Reset asserted mid-operation aborts the operation immediately.
- IDLE: on cmd_valid, latch the command and branch next cycle. cmd_valid outside IDLE is ignored.
- RX: capture the word on the first edge with data_valid=1, then enter DONE. data_ready rises in the capture cycle and stays high until done_read.
- TX: data_valid=1 with stable data. On the edge with data_ready=1, go to DONE. data_valid stays high until done_read so a late-sampling host still sees it.
- Multiplier: pulse start for one cycle, wait for its done, latch its result, then issue the next step. Exponent latency is ≈(2 + 512 + popcount(E)) multiplier calls.
- DONE: done=1 until the first edge with done_read=1, then IDLE. Nothing else advances in DONE.
- Back-to-back commands are accepted from the cycle IDLE is re-entered.

## Structure
- Shared package holds the command codes, the state enum, and the widths (OPW=512, BUSW=1024).
- Single sub-module `montgomery`:
  - Ports: clk, resetn, start, in_a, in_b, in_m (512 each), result (512), done (1-cycle pulse).
  - Computes a·b·2⁻⁵¹² mod M with variable latency.
- The wrapper is FSM, operand registers, and a 9-bit bit counter only.

## Test plan
- Mont: READ_MOD 7; READ_RSQ {B=3, A=2} → WRITE returns 5 in low 512 bits, upper half 0.
- Exp: M=7, READ_RSQ {x=3, R²mod7=2}, READ_EXP {Rmod7=4, e=5} → COMPUTE_EXP, WRITE returns 5.
- Exp with e=0 (same M, x) → result 1. Exp with e=1 → result 3.
- Handshake: hold done_read low 20 cycles → done stays 1, a new cmd_valid is ignored, and data_ready / data_valid stay asserted.
- Unknown cmd 9 → done within 3 cycles; registers unchanged (verify by WRITE).
- Reset pulse during COMPUTE_EXP → all outputs 0, state IDLE; a subsequent full Mont sequence works.
